// File: rtl/regfile_sb.sv
// Parametrised register file with hardware clear sequencer, hardwired-zero x0 and busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clock,
   input  logic            reset,
   output logic            ready,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] out1,
   output logic [XLEN-1:0] out2,
   output logic            busy1,
   output logic            busy2,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] inf,
   input  logic            we,
   input  logic            rsv_valid,
   input  logic [AW-1:0]   rsv_rd
);

   // Storage is indexed with just enough address bits for NREGS entries;
   // the full address is still range-checked before any access.
   localparam int            IW    = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [AW:0]   DEPTH = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t state;
   state_t nextstate;

   logic [AW-1:0]   count;
   logic            clearing;
   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;

   logic wrok;
   logic rsvok;
   logic rs1ok;
   logic rs2ok;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= CLEAR;
      end else begin
         state <= nextstate;
      end
   end

   always_comb begin
      nextstate = state;
      if (state == CLEAR && count == LAST) begin
         nextstate = READY;
      end
   end

   always_comb begin
      ready    = (state == READY);
      clearing = (state == CLEAR);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clearing) begin
         count <= count + 1'b1;
      end
   end

   // x0 and out-of-range addresses never qualify, so they can neither be written nor reserved.
   always_comb begin
      wrok  = ready && we && (rd != '0) && ({1'b0, rd} < DEPTH);
      rsvok = ready && rsv_valid && (rsv_rd != '0) && ({1'b0, rsv_rd} < DEPTH);
      rs1ok = ready && (rs1 != '0) && ({1'b0, rs1} < DEPTH);
      rs2ok = ready && (rs2 != '0) && ({1'b0, rs2} < DEPTH);
   end

   always_ff @(posedge clock) begin
      if (clearing) begin
         regs[count[IW-1:0]] <= '0;
      end else if (wrok) begin
         regs[rd[IW-1:0]] <= inf;
      end
   end

   // The reservation is applied after the writeback clear so a new producer wins on a tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy <= '0;
      end else begin
         if (wrok) begin
            busy[rd[IW-1:0]] <= 1'b0;
         end
         if (rsvok) begin
            busy[rsv_rd[IW-1:0]] <= 1'b1;
         end
      end
   end

   always_comb begin
      out1  = '0;
      busy1 = 1'b0;
      if (rs1ok) begin
         out1  = regs[rs1[IW-1:0]];
         busy1 = busy[rs1[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
         if (wrok && rd == rs1) begin
            out1 = inf;
            if (!(rsvok && rsv_rd == rs1)) begin
               busy1 = 1'b0;
            end
         end
`endif
      end
   end

   always_comb begin
      out2  = '0;
      busy2 = 1'b0;
      if (rs2ok) begin
         out2  = regs[rs2[IW-1:0]];
         busy2 = busy[rs2[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
         if (wrok && rd == rs2) begin
            out2 = inf;
            if (!(rsvok && rsv_rd == rs2)) begin
               busy2 = 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a 32-entry and a 16-entry instance driven by the same
// directed and random stimulus, checked against an array-based reference model.
module tb_regfile_sb;

   logic        clock;
   logic        reset;
   logic        we;
   logic        rsv_valid;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [4:0]  rsv_rd;
   logic [31:0] inf;

   logic        ready_a, busy1_a, busy2_a;
   logic [31:0] out1_a, out2_a;
   logic        ready_b, busy1_b, busy2_b;
   logic [31:0] out1_b, out2_b;

   regfile_sb #(.XLEN(32), .NREGS(32), .AW(5)) dut_a (
      .clock(clock), .reset(reset), .ready(ready_a),
      .rs1(rs1), .rs2(rs2), .out1(out1_a), .out2(out2_a),
      .busy1(busy1_a), .busy2(busy2_a),
      .rd(rd), .inf(inf), .we(we),
      .rsv_valid(rsv_valid), .rsv_rd(rsv_rd)
   );

   regfile_sb #(.XLEN(32), .NREGS(16), .AW(5)) dut_b (
      .clock(clock), .reset(reset), .ready(ready_b),
      .rs1(rs1), .rs2(rs2), .out1(out1_b), .out2(out2_b),
      .busy1(busy1_b), .busy2(busy2_b),
      .rd(rd), .inf(inf), .we(we),
      .rsv_valid(rsv_valid), .rsv_rd(rsv_rd)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      string            name;
      logic [1:0]       rdy;
      logic [1:0][31:0] o1;
      logic [1:0][31:0] o2;
      logic [1:0]       b1;
      logic [1:0]       b2;
   } exp_t;

   exp_t sbq [$];
   int   compared   = 0;
   int   mismatched = 0;

   // Reference model: register contents, busy flags and cycles spent clearing, per instance.
   int          depth [2] = '{32, 16};
   logic [31:0] mregs [2][32];
   bit          mbusy [2][32];
   int          mclr  [2];

   function automatic bit modelReady(input int k);
      return mclr[k] >= depth[k];
   endfunction

   function automatic void expectPort(input int k, input logic [4:0] a, input bit w,
                                      input logic [4:0] d, input logic [31:0] v,
                                      input bit rv, input logic [4:0] rr,
                                      output logic [31:0] o, output logic b);
      o = '0;
      b = 1'b0;
      if (modelReady(k) && a != 0 && int'(a) < depth[k]) begin
         o = mregs[k][a];
         b = mbusy[k][a];
`ifdef REGFILE_BYPASS_EN
         if (w && d == a) begin
            o = v;
            if (!(rv && rr == a)) b = 1'b0;
         end
`endif
      end
   endfunction

   task automatic updateModel(input int k, input bit r, input bit w, input logic [4:0] d,
                              input logic [31:0] v, input bit rv, input logic [4:0] rr);
      if (r) begin
         mclr[k] = 0;
         for (int i = 0; i < 32; i++) begin
            mregs[k][i] = '0;
            mbusy[k][i] = 1'b0;
         end
      end else if (!modelReady(k)) begin
         mclr[k]++;
      end else begin
         if (w && d != 0 && int'(d) < depth[k]) begin
            mregs[k][d] = v;
            mbusy[k][d] = 1'b0;
         end
         if (rv && rr != 0 && int'(rr) < depth[k]) begin
            mbusy[k][rr] = 1'b1;
         end
      end
   endtask

   // Drives one cycle of inputs, queues the expected outputs for that cycle, then advances the model.
   task automatic applyStimulus(input string name, input bit r, input bit w, input logic [4:0] d,
                                input logic [31:0] v, input bit rv, input logic [4:0] rr,
                                input logic [4:0] a1, input logic [4:0] a2, input bit chk);
      exp_t        e;
      logic [31:0] o;
      logic        b;
      reset     = r;
      we        = w;
      rd        = d;
      inf       = v;
      rsv_valid = rv;
      rsv_rd    = rr;
      rs1       = a1;
      rs2       = a2;
      if (chk) begin
         e.name = name;
         for (int k = 0; k < 2; k++) begin
            e.rdy[k] = modelReady(k);
            expectPort(k, a1, w, d, v, rv, rr, o, b);
            e.o1[k] = o;
            e.b1[k] = b;
            expectPort(k, a2, w, d, v, rv, rr, o, b);
            e.o2[k] = o;
            e.b2[k] = b;
         end
         sbq.push_back(e);
      end
      @(posedge clock);
      for (int k = 0; k < 2; k++) updateModel(k, r, w, d, v, rv, rr);
      #1;
   endtask

   task automatic cmp(input string name, input int k, input string field,
                      input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s %s (NREGS=%0d): got %h, expected %h", name, field, depth[k], act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      logic [1:0]       ar, ab1, ab2;
      logic [1:0][31:0] ao1, ao2;
      ar  = {ready_b, ready_a};
      ab1 = {busy1_b, busy1_a};
      ab2 = {busy2_b, busy2_a};
      ao1[0] = out1_a;
      ao1[1] = out1_b;
      ao2[0] = out2_a;
      ao2[1] = out2_b;
      for (int k = 0; k < 2; k++) begin
         cmp(e.name, k, "ready", 32'(ar[k]),  32'(e.rdy[k]));
         cmp(e.name, k, "out1",  ao1[k],      e.o1[k]);
         cmp(e.name, k, "out2",  ao2[k],      e.o2[k]);
         cmp(e.name, k, "busy1", 32'(ab1[k]), 32'(e.b1[k]));
         cmp(e.name, k, "busy2", 32'(ab2[k]), 32'(e.b2[k]));
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checkOutput(e);
      end
   end

   initial begin
      bit          r, w, rv;
      logic [4:0]  d, rr, a1, a2;
      for (int k = 0; k < 2; k++) mclr[k] = 0;

      applyStimulus("init",   1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("reset",  1, 0, 0, 0, 0, 0, 3, 9, 1);
      for (int i = 0; i < 10; i++)
         applyStimulus("clear1", 0, 1, 3, 32'hDEAD, 1, 9, 3, 9, 1);
      applyStimulus("midreset", 1, 1, 3, 32'hDEAD, 1, 9, 3, 9, 1);
      for (int i = 0; i < 36; i++)
         applyStimulus("clear2", 0, i < 20, 3, 32'hDEAD, i < 20, 9, 3, 9, 1);

      applyStimulus("wr2",    0, 1, 2,  32'h3,  0, 0, 3, 9,  1);
      applyStimulus("wr4",    0, 1, 4,  32'h7,  0, 0, 2, 0,  1);
      applyStimulus("wr0",    0, 1, 0,  32'h5,  0, 0, 2, 4,  1);
      applyStimulus("wr20",   0, 1, 20, 32'hAB, 0, 0, 0, 20, 1);
      applyStimulus("rd20",   0, 0, 0,  0,      0, 0, 20, 20, 1);

      applyStimulus("rsv5",   0, 0, 0, 0,      1, 5, 5, 6, 1);
      applyStimulus("busy5",  0, 0, 0, 0,      0, 0, 5, 6, 1);
      applyStimulus("wr5",    0, 1, 5, 32'h11, 0, 0, 5, 0, 1);
      applyStimulus("after5", 0, 0, 0, 0,      0, 0, 5, 0, 1);
      applyStimulus("rsv6",   0, 0, 0, 0,      1, 6, 0, 6, 1);
      applyStimulus("rsvwr6", 0, 1, 6, 32'h66, 1, 6, 6, 6, 1);
      applyStimulus("x0rsv",  0, 0, 0, 0,      1, 0, 6, 0, 1);
      applyStimulus("x0chk",  0, 0, 0, 0,      0, 0, 0, 6, 1);
      applyStimulus("wr6rsv7",0, 1, 6, 32'h67, 1, 7, 6, 7, 1);
      applyStimulus("chk67",  0, 0, 0, 0,      0, 0, 6, 7, 1);

      applyStimulus("wr8",    0, 1, 8, 32'h10, 0, 0, 8, 0, 1);
      applyStimulus("rdw8",   0, 1, 8, 32'h20, 0, 0, 8, 8, 1);
      applyStimulus("post8",  0, 0, 0, 0,      1, 8, 8, 8, 1);
      applyStimulus("rdwb8",  0, 1, 8, 32'h30, 0, 0, 8, 8, 1);
      applyStimulus("rsv8b",  0, 0, 0, 0,      1, 8, 8, 0, 1);
      applyStimulus("rdwrs8", 0, 1, 8, 32'h31, 1, 8, 8, 8, 1);
      applyStimulus("final8", 0, 0, 0, 0,      0, 0, 8, 8, 1);

      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 149) == 0);
         w  = 1'($urandom_range(0, 1));
         d  = 5'($urandom_range(0, 31));
         rv = ($urandom_range(0, 2) == 0);
         rr = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 2) == 0) ? d  : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? rr : 5'($urandom_range(0, 31));
         applyStimulus("random", r, w, d, $urandom, rv, rr, a1, a2, 1);
      end

      applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      if (sbq.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending entries, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Adds:
  - configurable width and depth;
  - synchronous reset with a hardware clear sequencer that zeroes every entry;
  - a hardwired-zero x0;
  - a per-register busy scoreboard for the decode/hazard logic.
- Sits between decode (rs1/rs2 reads, destination reservation) and writeback (rd/inf/we).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; legal range 2..2^AW.
- AW, 5, register address width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high when the clear sequence is done and the file accepts traffic.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- out1  out  XLEN  read data, port 1 (combinational).
- out2  out  XLEN  read data, port 2 (combinational).
- busy1  out  1  register rs1 has an outstanding reservation.
- busy2  out  1  register rs2 has an outstanding reservation.
- rd  in  AW  write address.
- inf  in  XLEN  write data.
- we  in  1  write enable.
- rsv_valid  in  1  reserve a destination register; issued by decode.
- rsv_rd  in  AW  register being reserved.

Behaviour:
- Reset and clear sequencer:
  - Clock is named `clock`; reset is synchronous and active-high.
  - Reset sampled high at a rising edge does all of the following at that edge:
    - state goes to CLEAR;
    - clear counter goes to 0;
    - ready goes to 0;
    - all busy bits go to 0.
- States: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to entry[counter], then increments the counter.
  - After entry NREGS-1 is written, state goes to READY.
  - ready goes to 1 on the same edge.
  - Latency from reset release to ready=1 is exactly NREGS cycles.
  - we and rsv_valid are ignored.
  - out1, out2, busy1 and busy2 are forced to 0.
- Reset asserted mid-CLEAR or in READY restarts the sequence at counter 0.
- Reads:
  - Asynchronous: outN = entry[rsN].
  - rsN = 0 returns 0.
  - rsN >= NREGS returns 0.
- Writes:
  - On a rising edge with ready=1, we=1, rd != 0 and rd < NREGS: entry[rd] <= inf.
  - Writes with rd = 0 or rd >= NREGS are dropped; no state changes.
- Scoreboard:
  - Set: ready=1, rsv_valid=1, rsv_rd != 0 and in range → busy[rsv_rd] <= 1.
  - Clear: a valid write (as above) → busy[rd] <= 0.
  - Set and clear on the same register in the same cycle: set wins, so busy stays 1 for the new producer.
  - Set and clear on different registers in the same cycle: both take effect.
  - Reserving an already-busy register keeps it busy. There is no counting: one write clears it.
  - x0 is never busy.
  - busyN = busy[rsN]; 0 when out of range.
- Read-during-write (same cycle, same register, macro off):
  - outN returns the old value.
  - busyN still shows 1 until the following cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding applies when ready=1, we=1, rd != 0, rd < NREGS and rd == rsN.
  - In that case outN = inf in the same cycle.
  - busyN = busy[rsN] & ~(we && rd == rsN) in the same cycle.
  - Exception: busyN stays 1 if rsv_valid is reserving that same register that cycle.
- Not defined:
  - No forwarding; read-during-write returns the old value.
  - busyN reflects the registered busy bit only.
  - Logic-identical otherwise.

Test Plan:
- Reset sequence, NREGS=32:
  - Stimulus: assert reset 1 cycle, then release.
  - Response: ready=0 for exactly 32 cycles, then 1.
  - During the clear, we=1, rd=3, inf=0xDEAD is ignored.
  - After ready: out1 for rs1=3 reads 0.
- Basic write/read:
  - Stimulus: we=1, rd=2, inf=3, then rd=4, inf=7.
  - Response: rs1=2 → out1=3; rs2=4 → out2=7.
  - rd=0, inf=5 is dropped: rs1=0 → out1=0.
- Scoreboard:
  - Reserve 5 (rsv_valid=1, rsv_rd=5) → busy1=1 for rs1=5 next cycle.
  - Write rd=5, inf=0x11 → busy1=0 next cycle, out1=0x11.
  - Reserve and write reg 6 in the same cycle → busy stays 1.
  - Reserve 0 → busy1 for rs1=0 stays 0.
- Read-during-write:
  - Stimulus: reg 8 = 0x10; same cycle we=1, rd=8, inf=0x20, rs1=8.
  - Response with the macro off: out1=0x10, then 0x20.
  - Response with REGFILE_BYPASS_EN: out1=0x20 immediately.
- Mid-clear reset and reserve-during-clear:
  - Reassert reset 10 cycles into the clear → ready rises NREGS cycles after the second release.
  - Reserve reg 9 during the clear → busy1 for rs1=9 reads 0 after ready.
- Reduced depth, NREGS=16:
  - write rd=20 dropped;
  - rs1=20 → out1=0, busy1=0;
  - ready after 16 cycles.
